// File: rtl/vaelix_sentinel_monitor_if.sv
// Observation bus between the Sentinel Lock and its runtime monitor.
// The monitor (slave) observes lock I/O and reports alarm and statistics.
interface vaelix_sentinel_monitor_if #(
  parameter int CNT_W = 8
);
  logic             ena;
  logic [7:0]       ui_in;
  logic [7:0]       uo_out;
  logic             clear;
  logic             alarm;
  logic             viol_pulse;
  logic [CNT_W-1:0] viol_count;
  logic [CNT_W-1:0] grant_count;
  logic [7:0]       viol_snap;

  modport master (
    output ena, ui_in, uo_out, clear,
    input  alarm, viol_pulse, viol_count, grant_count, viol_snap
  );

  modport slave (
    input  ena, ui_in, uo_out, clear,
    output alarm, viol_pulse, viol_count, grant_count, viol_snap
  );
endinterface

// File: rtl/vaelix_sentinel_monitor.sv
// Passive monitor for the Sentinel Lock: VERIFIED on uo_out must follow the
// full key sequence on ui_in by LATENCY cycles, else a sticky alarm is raised.
module vaelix_sentinel_monitor #(
  parameter int          KEY_LEN       = 2,
  parameter logic [63:0] KEY           = 64'hB63A,
  parameter logic [7:0]  VERIFIED_CODE = 8'hC1,
  parameter int          LATENCY       = 1,
  parameter bit          HOLD_OK       = 1'b1,
  parameter int          CNT_W         = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  vaelix_sentinel_monitor_if.slave mon
);
  localparam int D  = LATENCY + KEY_LEN - 1;
  localparam int FW = $clog2(D + 1);

  typedef enum logic {MONITOR, HELD} state_e;

  state_e                state_q, state_d;
  logic [D-1:0][7:0]     hist_q, hist_d;
  logic [FW-1:0]         fill_q, fill_d;
  logic                  alarm_q, alarm_d;
  logic                  pulse_q;
  logic [CNT_W-1:0]      viol_cnt_q, viol_cnt_d;
  logic [CNT_W-1:0]      grant_cnt_q, grant_cnt_d;
  logic [7:0]            snap_q, snap_d;
  logic                  ver, match, grant, viol;

  assign ver = mon.ena && (mon.uo_out == VERIFIED_CODE);

  // Key byte KEY_LEN-1 is the newest, so it sits LATENCY-1 slots deep.
  always_comb begin
    match = (fill_q == FW'(D));
    for (int j = 0; j < KEY_LEN; j++)
      if (hist_q[LATENCY-1+j] != KEY[8*(KEY_LEN-1-j) +: 8]) match = 1'b0;
  end

  always_comb begin
    hist_d    = hist_q;
    hist_d[0] = mon.ui_in;
    for (int k = 1; k < D; k++) hist_d[k] = hist_q[k-1];
    fill_d = (fill_q == FW'(D)) ? fill_q : fill_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    viol    = 1'b0;
    case (state_q)
      MONITOR: if (ver) begin
        if (match) begin
          grant = 1'b1;
          if (HOLD_OK) state_d = HELD;
        end else begin
          viol = 1'b1;
        end
      end
      HELD: if (!ver) state_d = MONITOR;
      default: state_d = MONITOR;
    endcase
  end

  // A violation or grant coinciding with clear counts as the first event.
  always_comb begin
    alarm_d     = viol ? 1'b1 : (mon.clear ? 1'b0 : alarm_q);
    viol_cnt_d  = mon.clear ? '0 : viol_cnt_q;
    grant_cnt_d = mon.clear ? '0 : grant_cnt_q;
    if (viol)  viol_cnt_d  = mon.clear ? CNT_W'(1) :
                             (&viol_cnt_q ? viol_cnt_q : viol_cnt_q + 1'b1);
    if (grant) grant_cnt_d = mon.clear ? CNT_W'(1) :
                             (&grant_cnt_q ? grant_cnt_q : grant_cnt_q + 1'b1);
    snap_d = viol ? hist_q[LATENCY-1] : snap_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MONITOR;
      hist_q      <= '0;
      fill_q      <= '0;
      alarm_q     <= 1'b0;
      pulse_q     <= 1'b0;
      viol_cnt_q  <= '0;
      grant_cnt_q <= '0;
      snap_q      <= '0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      alarm_q     <= alarm_d;
      pulse_q     <= viol;
      viol_cnt_q  <= viol_cnt_d;
      grant_cnt_q <= grant_cnt_d;
      snap_q      <= snap_d;
    end
  end

  assign mon.alarm       = alarm_q;
  assign mon.viol_pulse  = pulse_q;
  assign mon.viol_count  = viol_cnt_q;
  assign mon.grant_count = grant_cnt_q;
  assign mon.viol_snap   = snap_q;
endmodule

// File: tb/tb_vaelix_sentinel_monitor.sv
// Directed bench: default monitor, a no-hold variant, and a 1-byte/latency-3 variant.
module tb_vaelix_sentinel_monitor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vaelix_sentinel_monitor_if #(.CNT_W(8)) ifa ();
  vaelix_sentinel_monitor_if #(.CNT_W(8)) ifb ();
  vaelix_sentinel_monitor_if #(.CNT_W(8)) ifc ();

  vaelix_sentinel_monitor u_def (.clk(clk), .rst_n(rst_n), .mon(ifa.slave));
  vaelix_sentinel_monitor #(.HOLD_OK(1'b0)) u_nohold (.clk(clk), .rst_n(rst_n), .mon(ifb.slave));
  vaelix_sentinel_monitor #(.KEY_LEN(1), .KEY(64'hB6), .LATENCY(3)) u_k1 (
    .clk(clk), .rst_n(rst_n), .mon(ifc.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one monitor's inputs; the other two stay idle (ena=0).
  task automatic drv(input int sel, input logic [7:0] ui, input logic [7:0] uo,
                     input logic en, input logic clr);
    ifa.ena = 1'b0; ifa.ui_in = 8'h00; ifa.uo_out = 8'h00; ifa.clear = 1'b0;
    ifb.ena = 1'b0; ifb.ui_in = 8'h00; ifb.uo_out = 8'h00; ifb.clear = 1'b0;
    ifc.ena = 1'b0; ifc.ui_in = 8'h00; ifc.uo_out = 8'h00; ifc.clear = 1'b0;
    case (sel)
      0: begin ifa.ena = en; ifa.ui_in = ui; ifa.uo_out = uo; ifa.clear = clr; end
      1: begin ifb.ena = en; ifb.ui_in = ui; ifb.uo_out = uo; ifb.clear = clr; end
      default: begin ifc.ena = en; ifc.ui_in = ui; ifc.uo_out = uo; ifc.clear = clr; end
    endcase
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    drv(0, 8'h00, 8'h00, 1'b0, 1'b0);
    cyc(); cyc();
    chk("rst_alarm", 32'(ifa.alarm), 0);
    chk("rst_pulse", 32'(ifa.viol_pulse), 0);
    chk("rst_vcnt",  32'(ifa.viol_count), 0);
    chk("rst_gcnt",  32'(ifa.grant_count), 0);
    chk("rst_snap",  32'(ifa.viol_snap), 0);
    #3 rst_n = 1'b1;

    // legal grant: 3A, B6, then VERIFIED
    drv(0, 8'h3A, 8'h00, 1'b1, 1'b0); cyc();
    drv(0, 8'hB6, 8'h00, 1'b1, 1'b0); cyc();
    drv(0, 8'h00, 8'hC1, 1'b1, 1'b0); cyc();
    chk("grant_gcnt",  32'(ifa.grant_count), 1);
    chk("grant_alarm", 32'(ifa.alarm), 0);
    chk("grant_pulse", 32'(ifa.viol_pulse), 0);
    drv(0, 8'h00, 8'h00, 1'b1, 1'b0); cyc();

    // reversed key order
    drv(0, 8'hB6, 8'h00, 1'b1, 1'b0); cyc();
    drv(0, 8'h3A, 8'h00, 1'b1, 1'b0); cyc();
    drv(0, 8'h00, 8'hC1, 1'b1, 1'b0); cyc();
    chk("rev_alarm", 32'(ifa.alarm), 1);
    chk("rev_vcnt",  32'(ifa.viol_count), 1);
    chk("rev_snap",  32'(ifa.viol_snap), 32'h3A);
    chk("rev_pulse", 32'(ifa.viol_pulse), 1);
    drv(0, 8'h00, 8'h00, 1'b1, 1'b0); cyc();
    chk("rev_pulse_end", 32'(ifa.viol_pulse), 0);

    drv(0, 8'h00, 8'h00, 1'b1, 1'b1); cyc();
    chk("clr_alarm", 32'(ifa.alarm), 0);
    chk("clr_vcnt",  32'(ifa.viol_count), 0);
    chk("clr_gcnt",  32'(ifa.grant_count), 0);

    // hold after grant, HOLD_OK=1
    drv(0, 8'h3A, 8'h00, 1'b1, 1'b0); cyc();
    drv(0, 8'hB6, 8'h00, 1'b1, 1'b0); cyc();
    for (int i = 0; i < 5; i++) begin
      drv(0, 8'h00, 8'hC1, 1'b1, 1'b0); cyc();
    end
    chk("hold_vcnt",  32'(ifa.viol_count), 0);
    chk("hold_gcnt",  32'(ifa.grant_count), 1);
    chk("hold_alarm", 32'(ifa.alarm), 0);

    // same stimulus, HOLD_OK=0
    drv(1, 8'h3A, 8'h00, 1'b1, 1'b0); cyc();
    drv(1, 8'hB6, 8'h00, 1'b1, 1'b0); cyc();
    for (int i = 0; i < 5; i++) begin
      drv(1, 8'h00, 8'hC1, 1'b1, 1'b0); cyc();
      if (i >= 1) chk("nohold_pulse", 32'(ifb.viol_pulse), 1);
    end
    chk("nohold_vcnt", 32'(ifb.viol_count), 4);
    chk("nohold_gcnt", 32'(ifb.grant_count), 1);

    // key history straddling reset; reset acts without a clock edge
    drv(0, 8'h3A, 8'h00, 1'b1, 1'b0); cyc();
    rst_n = 1'b0;
    #1;
    chk("async_gcnt", 32'(ifa.grant_count), 0);
    chk("async_nb_vcnt", 32'(ifb.viol_count), 0);
    #2 rst_n = 1'b1;
    drv(0, 8'hB6, 8'h00, 1'b1, 1'b0); cyc();
    drv(0, 8'h00, 8'hC1, 1'b1, 1'b0); cyc();
    chk("straddle_alarm", 32'(ifa.alarm), 1);
    chk("straddle_vcnt",  32'(ifa.viol_count), 1);
    chk("straddle_snap",  32'(ifa.viol_snap), 32'hB6);

    // saturation, then clear colliding with a violation
    for (int i = 0; i < 300; i++) begin
      drv(0, 8'h00, 8'hC1, 1'b1, 1'b0); cyc();
    end
    chk("sat_vcnt",  32'(ifa.viol_count), 255);
    chk("sat_pulse", 32'(ifa.viol_pulse), 1);
    drv(0, 8'h00, 8'hC1, 1'b1, 1'b1); cyc();
    chk("clrviol_alarm", 32'(ifa.alarm), 1);
    chk("clrviol_vcnt",  32'(ifa.viol_count), 1);
    drv(0, 8'h00, 8'h00, 1'b1, 1'b1); cyc();
    chk("clr2_alarm", 32'(ifa.alarm), 0);
    chk("clr2_vcnt",  32'(ifa.viol_count), 0);

    // KEY_LEN=1, LATENCY=3
    drv(2, 8'hB6, 8'h00, 1'b1, 1'b0); cyc();
    drv(2, 8'h00, 8'h00, 1'b1, 1'b0); cyc();
    drv(2, 8'h00, 8'h00, 1'b1, 1'b0); cyc();
    drv(2, 8'h00, 8'hC1, 1'b1, 1'b0); cyc();
    chk("k1_gcnt",  32'(ifc.grant_count), 1);
    chk("k1_alarm", 32'(ifc.alarm), 0);
    drv(2, 8'h55, 8'h00, 1'b1, 1'b0); cyc();
    drv(2, 8'hB6, 8'h00, 1'b1, 1'b0); cyc();
    drv(2, 8'h00, 8'h00, 1'b1, 1'b0); cyc();
    drv(2, 8'h00, 8'hC1, 1'b1, 1'b0); cyc();
    chk("k1_early_alarm", 32'(ifc.alarm), 1);
    chk("k1_early_vcnt",  32'(ifc.viol_count), 1);
    chk("k1_early_snap",  32'(ifc.viol_snap), 32'h55);
    drv(2, 8'h00, 8'hC1, 1'b0, 1'b0); cyc();
    chk("k1_ena_pulse", 32'(ifc.viol_pulse), 0);
    chk("k1_ena_vcnt",  32'(ifc.viol_count), 1);
    chk("k1_ena_gcnt",  32'(ifc.grant_count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
